// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake, shifter strobes and serial line between host, shifter and the UART TX controller.
// The controller takes the slave modport; the host/shifter side takes master.
interface uart_tx_ctrl_if;
   logic       i_tx_start;
   logic [7:0] i_datain;
   logic       i_serialdata;
   logic       o_load;
   logic [7:0] o_load_data;
   logic       o_shift;
   logic       o_tx;
   logic       o_busy;
   logic       o_done;

   modport slave (
      input  i_tx_start,
      input  i_datain,
      input  i_serialdata,
      output o_load,
      output o_load_data,
      output o_shift,
      output o_tx,
      output o_busy,
      output o_done
   );

   modport master (
      output i_tx_start,
      output i_datain,
      output i_serialdata,
      input  o_load,
      input  o_load_data,
      input  o_shift,
      input  o_tx,
      input  o_busy,
      input  o_done
   );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: baud timing, shifter load/shift strobes and the start/data/parity/stop
// line mux for an external 8-bit PISO shifter whose output register feeds i_serialdata.
module uart_tx_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input logic           i_clk,
   input logic           i_rst_n,
   uart_tx_ctrl_if.slave bus
);

   localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic           ODD_MODE  = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic          parity_reg;
   logic [7:0]    data_reg;
   logic          load_q;
   logic          shift_q;
   logic          busy_q;
   logic          done_q;
   logic          tx_mux;
   logic          bit_end;
   logic          bit_pre;

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign bit_pre = (baud_cnt == BAUD_PRE);

   // Shift is registered one cycle early so it lands on the last cycle of START and data bits 0..6;
   // the shifter's output register then presents the next bit exactly at the following bit boundary.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         parity_reg <= 1'b0;
         data_reg   <= '0;
         load_q     <= 1'b0;
         shift_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         load_q  <= 1'b0;
         done_q  <= 1'b0;
         shift_q <= bit_pre && ((state == START) || ((state == DATA) && (bit_idx != 3'd7)));
         case (state)
            IDLE: begin
               if (bus.i_tx_start) begin
                  state      <= START;
                  baud_cnt   <= '0;
                  bit_idx    <= '0;
                  data_reg   <= bus.i_datain;
                  parity_reg <= (^bus.i_datain) ^ ODD_MODE;
                  load_q     <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     state   <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            PARITY: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= '0;
                     state   <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
               bit_idx  <= '0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   // Line level depends only on registered state, so reset forces it high without a low glitch.
   always_comb begin
      tx_mux = 1'b1;
      case (state)
         START:   tx_mux = 1'b0;
         DATA:    tx_mux = bus.i_serialdata;
         PARITY:  tx_mux = parity_reg;
         default: tx_mux = 1'b1;
      endcase
   end

   assign bus.o_tx        = tx_mux;
   assign bus.o_load      = load_q;
   assign bus.o_load_data = data_reg;
   assign bus.o_shift     = shift_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: four parameter sets, each with a behavioural PISO shifter,
// driven by a table of hand-computed frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] start;
   logic [7:0] din [4];
   wire  [3:0] tx_v;
   wire  [3:0] load_v;
   wire  [3:0] shift_v;
   wire  [3:0] busy_v;
   wire  [3:0] done_v;

   int checks_total  = 0;
   int checks_passed = 0;

   always #5 clk = ~clk;

   // dut0: N=4 no parity 1 stop; dut1: N=4 even parity; dut2: N=4 two stops; dut3: N=2 odd parity
   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int N_G  = (g == 3) ? 2 : 4;
      localparam int PE_G = (g == 1 || g == 3) ? 1 : 0;
      localparam int PO_G = (g == 3) ? 1 : 0;
      localparam int SB_G = (g == 2) ? 2 : 1;

      uart_tx_ctrl_if bus ();
      logic [7:0] sh_reg;
      logic       sh_out;

      uart_tx_ctrl #(
         .CLKS_PER_BIT (N_G),
         .PARITY_EN    (PE_G),
         .PARITY_ODD   (PO_G),
         .STOP_BITS    (SB_G)
      ) dut (
         .i_clk   (clk),
         .i_rst_n (rst_n),
         .bus     (bus)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sh_reg <= '0;
            sh_out <= 1'b1;
         end else if (bus.o_load) begin
            sh_reg <= bus.o_load_data;
         end else if (bus.o_shift) begin
            sh_out <= sh_reg[0];
            sh_reg <= {1'b0, sh_reg[7:1]};
         end
      end

      assign bus.i_tx_start   = start[g];
      assign bus.i_datain     = din[g];
      assign bus.i_serialdata = sh_out;
      assign tx_v[g]          = bus.o_tx;
      assign load_v[g]        = bus.o_load;
      assign shift_v[g]       = bus.o_shift;
      assign busy_v[g]        = bus.o_busy;
      assign done_v[g]        = bus.o_done;
   end

   typedef struct {
      string      name;
      int         dut;
      logic [7:0] data;
      logic [11:0] bits;
      int         nbits;
      int         n;
   } vec_t;

   vec_t vecs [7];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks_total++;
      if (actual == expected) checks_passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // One frame from a table record; bits[i] is the expected line level during bit period i.
   task automatic applyStimulus(input vec_t v);
      int f;
      int b;
      int load_cnt  = 0;
      int shift_cnt = 0;
      int load_err  = 0;
      int shift_err = 0;
      int busy_err  = 0;
      int done_err  = 0;
      int overlap   = 0;
      int glitch    = 0;
      int idle_tx   = 0;
      logic exp_shift;
      logic [11:0] obs;
      obs = '0;
      f   = v.nbits * v.n;
      @(negedge clk);
      start[v.dut] = 1'b1;
      din[v.dut]   = v.data;
      for (int c = 1; c <= f + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start[v.dut] = 1'b0;
            din[v.dut]   = ~v.data;
         end
         if (c <= f) begin
            b = (c - 1) / v.n;
            if ((c - 1) % v.n == 0) obs[b] = tx_v[v.dut];
            else if (tx_v[v.dut] != obs[b]) glitch++;
         end else begin
            idle_tx = int'(tx_v[v.dut]);
         end
         exp_shift = (c <= f) && (c % v.n == 0) && (c / v.n <= 8);
         load_cnt  += int'(load_v[v.dut]);
         shift_cnt += int'(shift_v[v.dut]);
         if (load_v[v.dut] != (c == 1)) load_err++;
         if (shift_v[v.dut] != exp_shift) shift_err++;
         if (busy_v[v.dut] != (c <= f)) busy_err++;
         if (done_v[v.dut] != (c == f + 1)) done_err++;
         if (load_v[v.dut] && shift_v[v.dut]) overlap++;
      end
      for (int i = 0; i < v.nbits; i++)
         checkOutput($sformatf("%s bit%0d level", v.name, i), int'(obs[i]), int'(v.bits[i]));
      checkOutput($sformatf("%s load count", v.name), load_cnt, 1);
      checkOutput($sformatf("%s shift count", v.name), shift_cnt, 8);
      checkOutput($sformatf("%s load timing errors", v.name), load_err, 0);
      checkOutput($sformatf("%s shift timing errors", v.name), shift_err, 0);
      checkOutput($sformatf("%s busy errors", v.name), busy_err, 0);
      checkOutput($sformatf("%s done errors", v.name), done_err, 0);
      checkOutput($sformatf("%s load/shift overlap", v.name), overlap, 0);
      checkOutput($sformatf("%s in-bit glitches", v.name), glitch, 0);
      checkOutput($sformatf("%s tx after frame", v.name), idle_tx, 1);
   endtask

   // Start held high on dut0: 0x55 then 0xFF, second start bit one cycle after the first done.
   task automatic runBackToBack();
      logic [9:0] bits55;
      logic [9:0] bitsff;
      logic       exp_tx;
      int tx_err = 0;
      int done_cnt = 0;
      int first_done = 0;
      int second_done = 0;
      int load_cnt = 0;
      int second_load = 0;
      int busy_gap = 1;
      int busy_after = 0;
      int tx_low_after = 0;
      bits55 = 10'b1_01010101_0;
      bitsff = 10'b1_11111111_0;
      @(negedge clk);
      start[0] = 1'b1;
      din[0]   = 8'h55;
      for (int c = 1; c <= 82; c++) begin
         @(negedge clk);
         if (c == 1)  din[0]   = 8'hFF;
         if (c == 50) start[0] = 1'b0;
         if (c <= 40)      exp_tx = bits55[(c - 1) / 4];
         else if (c == 41) exp_tx = 1'b1;
         else if (c <= 81) exp_tx = bitsff[(c - 42) / 4];
         else              exp_tx = 1'b1;
         if (tx_v[0] != exp_tx) tx_err++;
         if (done_v[0]) begin
            done_cnt++;
            if (first_done == 0) first_done = c;
            else second_done = c;
         end
         if (load_v[0]) begin
            load_cnt++;
            if (c == 42) second_load = 1;
         end
         if (c == 41) busy_gap = int'(busy_v[0]);
      end
      for (int c = 83; c <= 86; c++) begin
         @(negedge clk);
         if (busy_v[0]) busy_after = 1;
         if (!tx_v[0]) tx_low_after = 1;
      end
      checkOutput("b2b tx level errors", tx_err, 0);
      checkOutput("b2b done count", done_cnt, 2);
      checkOutput("b2b first done cycle", first_done, 41);
      checkOutput("b2b second done cycle", second_done, 82);
      checkOutput("b2b load count", load_cnt, 2);
      checkOutput("b2b second load at T+42", second_load, 1);
      checkOutput("b2b busy in gap cycle", busy_gap, 0);
      checkOutput("b2b extra frame busy", busy_after, 0);
      checkOutput("b2b extra frame tx low", tx_low_after, 0);
   endtask

   // Reset pulled during data bit 3 of a 0xF0 frame on dut0.
   task automatic runMidFrameReset();
      int bad_tx = 0;
      int bad_busy = 0;
      int bad_done = 0;
      @(negedge clk);
      start[0] = 1'b1;
      din[0]   = 8'hF0;
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         if (c == 1) start[0] = 1'b0;
      end
      checkOutput("reset pre tx (bit3 of F0)", int'(tx_v[0]), 0);
      rst_n = 1'b0;
      #1;
      checkOutput("reset async tx", int'(tx_v[0]), 1);
      checkOutput("reset async busy", int'(busy_v[0]), 0);
      checkOutput("reset async done", int'(done_v[0]), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (!tx_v[0]) bad_tx++;
         if (busy_v[0]) bad_busy++;
         if (done_v[0]) bad_done++;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (!tx_v[0]) bad_tx++;
         if (busy_v[0]) bad_busy++;
         if (done_v[0]) bad_done++;
      end
      checkOutput("reset held tx low cycles", bad_tx, 0);
      checkOutput("reset held busy cycles", bad_busy, 0);
      checkOutput("reset held done pulses", bad_done, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{"n4 A5",        0, 8'hA5, 12'(10'b1_10100101_0),        10, 4};
      vecs[1] = '{"n4 3C",        0, 8'h3C, 12'(10'b1_00111100_0),        10, 4};
      vecs[2] = '{"even A5",      1, 8'hA5, 12'(11'b1_0_10100101_0),      11, 4};
      vecs[3] = '{"even 07",      1, 8'h07, 12'(11'b1_1_00000111_0),      11, 4};
      vecs[4] = '{"2stop 00",     2, 8'h00, 12'(11'b11_00000000_0),       11, 4};
      vecs[5] = '{"n2 odd A5",    3, 8'hA5, 12'(11'b1_1_10100101_0),      11, 2};
      vecs[6] = '{"n2 odd 81",    3, 8'h81, 12'(11'b1_1_10000001_0),      11, 2};

      rst_n = 1'b0;
      start = '0;
      for (int i = 0; i < 4; i++) din[i] = 8'h00;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("reset outputs dut%0d {tx,load,shift,busy,done}", i),
                     int'({tx_v[i], load_v[i], shift_v[i], busy_v[i], done_v[i]}), 5'b10000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
      runBackToBack();
      runMidFrameReset();
      applyStimulus(vecs[1]);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
